// File: rtl/reaction_timer_pkg.sv
// Shared types, limits and BCD helpers for the reaction timer slice.
// The state encoding is fixed so that unused codes can be trapped back to IDLE.
package reaction_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        TIMING  = 3'd2,
        DONE    = 3'd3,
        EARLY   = 3'd4,
        TIMEOUT = 3'd5
    } state_t;

    localparam int unsigned MAX_MS = 9999;

    typedef logic [3:0][3:0] bcd4_t;

    typedef struct packed {
        logic led;
        logic busy;
        logic valid;
        logic early;
        logic timeout;
    } flags_t;

    // Moore flag decode; illegal codes show no flags at all.
    function automatic flags_t state_flags(input state_t s);
        flags_t f;
        f = flags_t'(5'b00000);
        case (s)
            ARMED:   f.busy = 1'b1;
            TIMING:  begin
                f.busy = 1'b1;
                f.led  = 1'b1;
            end
            DONE:    f.valid   = 1'b1;
            EARLY:   f.early   = 1'b1;
            TIMEOUT: f.timeout = 1'b1;
            default: f = flags_t'(5'b00000);
        endcase
        return f;
    endfunction

    function automatic bcd4_t bcd4_inc(input bcd4_t v);
        bcd4_t r;
        logic  carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[i] == 4'd9) begin
                    r[i] = 4'd0;
                end else begin
                    r[i]  = v[i] + 4'd1;
                    carry = 1'b0;
                end
            end else begin
                r[i] = v[i];
            end
        end
        return r;
    endfunction

    function automatic logic bcd4_is_max(input bcd4_t v);
        return (v == bcd4_t'(16'h9999));
    endfunction

endpackage

// File: rtl/reaction_timer_if.sv
// Control and result bundle between the game sequencer and the reaction timer.
// The sequencer side is the master; the timer itself takes the slave view.
interface reaction_timer_if;
    logic        en;
    logic        clr;
    logic        countdone;
    logic        stop;
    logic        led;
    logic        busy;
    logic        valid;
    logic        early;
    logic        timeout;
    logic [15:0] digits;

    modport master (
        output en, clr, countdone, stop,
        input  led, busy, valid, early, timeout, digits
    );

    modport slave (
        input  en, clr, countdone, stop,
        output led, busy, valid, early, timeout, digits
    );
endinterface

// File: rtl/reaction_timer_bcd_counter4.sv
// Four-digit BCD millisecond counter; clear beats increment, and it never
// advances past 9999 so the display cannot wrap.
module bcd_counter4
    import reaction_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  clr,
    input  logic  inc,
    output bcd4_t q,
    output logic  at_max
);

    bcd4_t q_r;

    // Digit register: reset/clear to 0000, otherwise ripple-carry BCD increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r <= bcd4_t'(16'h0000);
        end else if (clr) begin
            q_r <= bcd4_t'(16'h0000);
        end else if (inc && !bcd4_is_max(q_r)) begin
            q_r <= bcd4_inc(q_r);
        end else begin
            q_r <= q_r;
        end
    end

    assign q      = q_r;
    assign at_max = bcd4_is_max(q_r);

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer: arms on en, flags false starts, then counts milliseconds in
// BCD from countdone until the stop button rises or the count saturates.
module reaction_timer
    import reaction_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned TICK_DIV = CLK_HZ / 1000
) (
    input logic            clk,
    input logic            reset,
    reaction_timer_if.slave bus
);

    localparam int unsigned   PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ZERO = PW'(1'b0);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1'b1);

    state_t        state_r;
    state_t        state_nxt_s;
    flags_t        flags_r;
    logic [PW-1:0] presc_r;
    logic          stop_q_r;
    logic          en_q_r;
    logic          stop_rise_s;
    logic          en_rise_s;
    logic          tick_s;
    logic          cnt_clr_s;
    logic          cnt_inc_s;
    logic          at_max_s;
    bcd4_t         digits_s;

    assign stop_rise_s = bus.stop & ~stop_q_r;
    assign en_rise_s   = bus.en & ~en_q_r;
    assign tick_s      = (state_r == TIMING) && (presc_r == TICK_LAST);

    // Next-state and counter control; clr out of any busy/result state wins.
    always_comb begin
        state_nxt_s = state_r;
        cnt_clr_s   = 1'b0;
        cnt_inc_s   = 1'b0;
        if ((state_r != IDLE) && bus.clr) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (en_rise_s) begin
                        state_nxt_s = ARMED;
                        cnt_clr_s   = 1'b1;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                ARMED: begin
                    if (stop_rise_s) begin
                        state_nxt_s = EARLY;
                    end else if (bus.countdone) begin
                        state_nxt_s = TIMING;
                        cnt_clr_s   = 1'b1;
                    end else begin
                        state_nxt_s = ARMED;
                    end
                end
                TIMING: begin
                    // A tick landing on the stop edge is dropped, not counted.
                    if (stop_rise_s) begin
                        state_nxt_s = DONE;
                    end else if (tick_s) begin
                        if (at_max_s) begin
                            state_nxt_s = TIMEOUT;
                        end else begin
                            cnt_inc_s   = 1'b1;
                        end
                    end else begin
                        state_nxt_s = TIMING;
                    end
                end
                DONE, EARLY, TIMEOUT: state_nxt_s = state_r;
                default:              state_nxt_s = IDLE;
            endcase
        end
    end

    // State, registered flags, edge-detect history and millisecond prescaler.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            flags_r  <= state_flags(IDLE);
            presc_r  <= PRESC_ZERO;
            stop_q_r <= 1'b1;
            en_q_r   <= 1'b1;
        end else begin
            state_r  <= state_nxt_s;
            flags_r  <= state_flags(state_nxt_s);
            stop_q_r <= bus.stop;
            en_q_r   <= bus.en;
            if ((state_r == TIMING) && (state_nxt_s == TIMING)) begin
                presc_r <= tick_s ? PRESC_ZERO : (presc_r + PRESC_ONE);
            end else begin
                presc_r <= PRESC_ZERO;
            end
        end
    end

    bcd_counter4 u_bcd (
        .clk    (clk),
        .reset  (reset),
        .clr    (cnt_clr_s),
        .inc    (cnt_inc_s),
        .q      (digits_s),
        .at_max (at_max_s)
    );

    assign bus.led     = flags_r.led;
    assign bus.busy    = flags_r.busy;
    assign bus.valid   = flags_r.valid;
    assign bus.early   = flags_r.early;
    assign bus.timeout = flags_r.timeout;
    assign bus.digits  = digits_s;

endmodule
